reg_file: RTL



---
 rtl/reg_file_if.sv | 28 ++
 rtl/reg_file.sv | 75 +++++++
 2 files changed

// File: rtl/reg_file_if.sv
// Bus between the write-back/decode stages and the architectural register file.
// Carries the write-back port, two read ports and the load-scoreboard signals.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              LoadIssue;
  logic [ADDR_W-1:0] LoadDest;
  logic              Hazard1;
  logic              Hazard2;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, LoadIssue, LoadDest,
    input  ReadData1, ReadData2, Hazard1, Hazard2
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, LoadIssue, LoadDest,
    output ReadData1, ReadData2, Hazard1, Hazard2
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with two combinational read ports and a load scoreboard.
// Optional write-first forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  reg_file_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_hz1;
  logic              w_hz2;

  assign w_wr_en = bus.RegWrite && (bus.WriteReg != '0);

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  // Clear on write-back first, then set on load issue so a same-edge new load stays outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.RegWrite) w_busy_nxt[bus.WriteReg] = 1'b0;
    if (bus.LoadIssue && (bus.LoadDest != '0)) w_busy_nxt[bus.LoadDest] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_comb begin
    w_rd1 = (bus.ReadReg1 == '0) ? '0 : r_regs[bus.ReadReg1];
    w_rd2 = (bus.ReadReg2 == '0) ? '0 : r_regs[bus.ReadReg2];
    w_hz1 = r_busy[bus.ReadReg1] && (bus.ReadReg1 != '0);
    w_hz2 = r_busy[bus.ReadReg2] && (bus.ReadReg2 != '0);
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (bus.WriteReg == bus.ReadReg1)) begin
      w_rd1 = bus.WriteData;
      w_hz1 = 1'b0;
    end
    if (w_wr_en && (bus.WriteReg == bus.ReadReg2)) begin
      w_rd2 = bus.WriteData;
      w_hz2 = 1'b0;
    end
`else
`endif
    // Outputs are held at zero for the whole reset, including any forwarded word.
    if (rst) begin
      w_rd1 = '0;
      w_rd2 = '0;
      w_hz1 = 1'b0;
      w_hz2 = 1'b0;
    end
  end

  assign bus.ReadData1 = w_rd1;
  assign bus.ReadData2 = w_rd2;
  assign bus.Hazard1   = w_hz1;
  assign bus.Hazard2   = w_hz2;
endmodule
